// File: rtl/ds_hazard_ctrl_pkg.sv
// Shared constants for the decode-stage hazard controller: forwarding-select
// encodings and the stage-tag layout {v, dest, ld}.
package ds_hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_ES = 2'b01;
  localparam logic [1:0] FWD_MS = 2'b10;
  localparam logic [1:0] FWD_WS = 2'b11;

  localparam int REG_AW_DFLT = 5;
  localparam int HZ_TAG_WD   = 1 + REG_AW_DFLT + 1;

  // Tag width for an arbitrary register-address width.
  function automatic int hz_tag_wd(input int aw);
    return 1 + aw + 1;
  endfunction

endpackage

// File: rtl/ds_hazard_ctrl_hz_src_check.sv
// Per-operand hazard check: matches one decode source against the EX/MEM/WB
// tags, picks the youngest producer and requests a stall when it cannot forward.
// Forwarding is only built when DS_HAZARD_FWD_EN is defined.
module hz_src_check
  import ds_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW            = 5,
  parameter bit LOAD_FWD_FROM_MEM = 1'b1,
  localparam int TW               = 1 + REG_AW + 1
) (
  input  logic              valid_i,
  input  logic [REG_AW-1:0] addr_i,
  input  logic              used_i,
  input  logic [TW-1:0]     es_tag_i,
  input  logic [TW-1:0]     ms_tag_i,
  input  logic [TW-1:0]     ws_tag_i,
  output logic              stall_o,
  output logic [1:0]        sel_o
);

  logic rd_ok;
  logic hit_es;
  logic hit_ms;
  logic hit_ws;

  function automatic logic tag_hit(input logic [TW-1:0] tag, input logic [REG_AW-1:0] a);
    return tag[TW-1] && (tag[REG_AW:1] == a);
  endfunction

  assign rd_ok  = valid_i & used_i & (addr_i != '0);
  assign hit_es = rd_ok & tag_hit(es_tag_i, addr_i);
  assign hit_ms = rd_ok & tag_hit(ms_tag_i, addr_i);
  assign hit_ws = rd_ok & tag_hit(ws_tag_i, addr_i);

`ifdef DS_HAZARD_FWD_EN
  logic unused_ws_ld;
  assign unused_ws_ld = ws_tag_i[0];

  always_comb begin
    sel_o   = FWD_RF;
    stall_o = 1'b0;
    if (hit_es) begin
      sel_o   = FWD_ES;
      stall_o = es_tag_i[0];
    end else if (hit_ms) begin
      sel_o   = FWD_MS;
      stall_o = ms_tag_i[0] & ~LOAD_FWD_FROM_MEM;
    end else if (hit_ws) begin
      sel_o   = FWD_WS;
    end
  end
`else
  // Without forwarding the RF is the only source, so any in-flight writer blocks.
  localparam bit unused_lfm = LOAD_FWD_FROM_MEM;
  logic unused_ld;
  assign unused_ld = ^{es_tag_i[0], ms_tag_i[0], ws_tag_i[0], unused_lfm};

  always_comb begin
    sel_o   = FWD_RF;
    stall_o = hit_es | hit_ms | hit_ws;
  end
`endif

endmodule

// File: rtl/ds_hazard_ctrl.sv
// Decode-stage scoreboard/interlock: tracks EX/MEM/WB destination tags, drives
// ds_stall, per-operand forwarding selects and a stall-cycle counter.
// Optional forwarding is enabled by defining DS_HAZARD_FWD_EN.
module ds_hazard_ctrl
  import ds_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW            = 5,
  parameter int CNT_W             = 32,
  parameter bit LOAD_FWD_FROM_MEM = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ds_valid,
  input  logic [REG_AW-1:0] ds_raddr1,
  input  logic [REG_AW-1:0] ds_raddr2,
  input  logic              ds_src1_used,
  input  logic              ds_src2_used,
  input  logic [REG_AW-1:0] ds_dest,
  input  logic              ds_gr_we,
  input  logic              ds_is_load,
  input  logic              ds_go,
  input  logic              es_go,
  input  logic              ms_go,
  input  logic              ws_go,
  output logic              ds_stall,
  output logic [1:0]        fwd_sel1,
  output logic [1:0]        fwd_sel2,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int TW = hz_tag_wd(REG_AW);

  logic [TW-1:0]    es_tag_q, es_tag_d;
  logic [TW-1:0]    ms_tag_q, ms_tag_d;
  logic [TW-1:0]    ws_tag_q, ws_tag_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic       stall1, stall2;
  logic [1:0] sel1, sel2;

  // A stage that loads and drains in the same cycle takes the new tag.
  always_comb begin
    es_tag_d = es_tag_q;
    if (ds_go)      es_tag_d = {ds_gr_we & (ds_dest != '0), ds_dest, ds_is_load};
    else if (es_go) es_tag_d[TW-1] = 1'b0;

    ms_tag_d = ms_tag_q;
    if (es_go)      ms_tag_d = es_tag_q;
    else if (ms_go) ms_tag_d[TW-1] = 1'b0;

    ws_tag_d = ws_tag_q;
    if (ms_go)      ws_tag_d = ms_tag_q;
    else if (ws_go) ws_tag_d[TW-1] = 1'b0;

    stall_cnt_d = stall_cnt_q;
    if (ds_valid && ds_stall) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      es_tag_q    <= '0;
      ms_tag_q    <= '0;
      ws_tag_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      es_tag_q    <= es_tag_d;
      ms_tag_q    <= ms_tag_d;
      ws_tag_q    <= ws_tag_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  hz_src_check #(
    .REG_AW            (REG_AW),
    .LOAD_FWD_FROM_MEM (LOAD_FWD_FROM_MEM)
  ) u_src1 (
    .valid_i  (ds_valid),
    .addr_i   (ds_raddr1),
    .used_i   (ds_src1_used),
    .es_tag_i (es_tag_q),
    .ms_tag_i (ms_tag_q),
    .ws_tag_i (ws_tag_q),
    .stall_o  (stall1),
    .sel_o    (sel1)
  );

  hz_src_check #(
    .REG_AW            (REG_AW),
    .LOAD_FWD_FROM_MEM (LOAD_FWD_FROM_MEM)
  ) u_src2 (
    .valid_i  (ds_valid),
    .addr_i   (ds_raddr2),
    .used_i   (ds_src2_used),
    .es_tag_i (es_tag_q),
    .ms_tag_i (ms_tag_q),
    .ws_tag_i (ws_tag_q),
    .stall_o  (stall2),
    .sel_o    (sel2)
  );

  assign ds_stall  = rst & (stall1 | stall2);
  assign fwd_sel1  = rst ? sel1 : FWD_RF;
  assign fwd_sel2  = rst ? sel2 : FWD_RF;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ds_hazard_ctrl.sv
// Directed bench for ds_hazard_ctrl: two instances (load forwardable from MEM
// or only from WB) share one stimulus stream; expectations follow DS_HAZARD_FWD_EN.
module tb_ds_hazard_ctrl;

`ifdef DS_HAZARD_FWD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ds_valid, ds_src1_used, ds_src2_used, ds_gr_we, ds_is_load;
  logic        ds_go, es_go, ms_go, ws_go;
  logic [4:0]  ds_raddr1, ds_raddr2, ds_dest;
  logic        stall_a, stall_b;
  logic [1:0]  sel1_a, sel2_a, sel1_b, sel2_b;
  logic [31:0] cnt_a, cnt_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ds_hazard_ctrl #(.REG_AW(5), .CNT_W(32), .LOAD_FWD_FROM_MEM(1'b1)) dut_a (
    .clk(clk), .rst(rst), .ds_valid(ds_valid), .ds_raddr1(ds_raddr1), .ds_raddr2(ds_raddr2),
    .ds_src1_used(ds_src1_used), .ds_src2_used(ds_src2_used), .ds_dest(ds_dest),
    .ds_gr_we(ds_gr_we), .ds_is_load(ds_is_load), .ds_go(ds_go), .es_go(es_go),
    .ms_go(ms_go), .ws_go(ws_go), .ds_stall(stall_a), .fwd_sel1(sel1_a),
    .fwd_sel2(sel2_a), .stall_cnt(cnt_a)
  );

  ds_hazard_ctrl #(.REG_AW(5), .CNT_W(32), .LOAD_FWD_FROM_MEM(1'b0)) dut_b (
    .clk(clk), .rst(rst), .ds_valid(ds_valid), .ds_raddr1(ds_raddr1), .ds_raddr2(ds_raddr2),
    .ds_src1_used(ds_src1_used), .ds_src2_used(ds_src2_used), .ds_dest(ds_dest),
    .ds_gr_we(ds_gr_we), .ds_is_load(ds_is_load), .ds_go(ds_go), .es_go(es_go),
    .ms_go(ms_go), .ws_go(ws_go), .ds_stall(stall_b), .fwd_sel1(sel1_b),
    .fwd_sel2(sel2_b), .stall_cnt(cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Downstream stages always drain; ds_go is chosen per step by the bench.
  task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic u1,
                       input logic u2, input logic [4:0] d, input logic we,
                       input logic ld, input logic go);
    ds_valid = 1'b1; ds_raddr1 = a1; ds_raddr2 = a2;
    ds_src1_used = u1; ds_src2_used = u2; ds_dest = d;
    ds_gr_we = we; ds_is_load = ld; ds_go = go;
    es_go = 1'b1; ms_go = 1'b1; ws_go = 1'b1;
    #1;
  endtask

  task automatic idle();
    ds_valid = 1'b0; ds_go = 1'b0; ds_src1_used = 1'b0; ds_src2_used = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    idle();
    ds_raddr1 = '0; ds_raddr2 = '0; ds_dest = '0; ds_gr_we = 1'b0; ds_is_load = 1'b0;
    es_go = 1'b0; ms_go = 1'b0; ws_go = 1'b0;
    #2;
    chk("rst_stall", stall_a, 0);
    chk("rst_sel1", sel1_a, 0);
    chk("rst_sel2", sel2_a, 0);
    chk("rst_cnt", cnt_a, 0);
    tick();
    rst = 1'b1;

    // add.w r3,r1,r2 ; add.w r4,r3,r0
    drive(1, 2, 1, 1, 3, 1, 0, 1);
    chk("alu_p_stall", stall_a, 0);
    chk("alu_p_sel1", sel1_a, 0);
    tick();
    drive(3, 0, 1, 1, 4, 1, 0, FWD);
    chk("alu_c_stall", stall_a, {31'd0, ~FWD});
    chk("alu_c_sel1", sel1_a, FWD ? 32'd1 : 32'd0);
    chk("alu_c_sel2", sel2_a, 0);
    tick();
`ifdef DS_HAZARD_FWD_EN
    drive(3, 12, 1, 0, 13, 1, 0, 1);
    chk("alu_mem_sel1", sel1_a, 2);
    chk("alu_mem_stall", stall_a, 0);
    chk("alu_cnt", cnt_a, 0);
`else
    drive(3, 0, 1, 1, 4, 1, 0, 0);
    chk("alu_c2_stall", stall_a, 1);
    chk("alu_c2_sel1", sel1_a, 0);
    tick();
    drive(3, 0, 1, 1, 4, 1, 0, 0);
    chk("alu_c3_stall", stall_a, 1);
    chk("alu_c3_sel1", sel1_a, 0);
    tick();
    drive(3, 0, 1, 1, 4, 1, 0, 1);
    chk("alu_c4_stall", stall_a, 0);
    chk("alu_cnt", cnt_a, 3);
`endif
    tick();
    do_reset();

    // ld.w r5 ; add.w r6,r5,r5 with load forwardable from MEM
    drive(1, 0, 1, 0, 5, 1, 1, 1);
    chk("ldA_p_stall", stall_a, 0);
    tick();
    drive(5, 5, 1, 1, 6, 1, 0, 0);
    chk("ldA_c1_stall", stall_a, 1);
    chk("ldA_c1_sel1", sel1_a, FWD ? 32'd1 : 32'd0);
    tick();
`ifdef DS_HAZARD_FWD_EN
    drive(5, 5, 1, 1, 6, 1, 0, 1);
    chk("ldA_c2_stall", stall_a, 0);
    chk("ldA_c2_sel1", sel1_a, 2);
    chk("ldA_c2_sel2", sel2_a, 2);
    chk("ldA_cnt", cnt_a, 1);
`else
    drive(5, 5, 1, 1, 6, 1, 0, 0);
    chk("ldA_c2_stall", stall_a, 1);
    tick();
    drive(5, 5, 1, 1, 6, 1, 0, 0);
    chk("ldA_c3_stall", stall_a, 1);
    tick();
    drive(5, 5, 1, 1, 6, 1, 0, 1);
    chk("ldA_c4_stall", stall_a, 0);
    chk("ldA_c4_sel1", sel1_a, 0);
    chk("ldA_cnt", cnt_a, 3);
`endif
    tick();
    do_reset();

    // Same pair, load forwardable only from WB
    drive(1, 0, 1, 0, 5, 1, 1, 1);
    tick();
    drive(5, 5, 1, 1, 6, 1, 0, 0);
    chk("ldB_c1_stall", stall_b, 1);
    tick();
    drive(5, 5, 1, 1, 6, 1, 0, 0);
    chk("ldB_c2_stall", stall_b, 1);
    chk("ldB_c2_sel1", sel1_b, FWD ? 32'd2 : 32'd0);
    tick();
`ifdef DS_HAZARD_FWD_EN
    drive(5, 5, 1, 1, 6, 1, 0, 1);
    chk("ldB_c3_stall", stall_b, 0);
    chk("ldB_c3_sel1", sel1_b, 3);
    chk("ldB_c3_sel2", sel2_b, 3);
    chk("ldB_cnt", cnt_b, 2);
`else
    drive(5, 5, 1, 1, 6, 1, 0, 0);
    chk("ldB_c3_stall", stall_b, 1);
    tick();
    drive(5, 5, 1, 1, 6, 1, 0, 1);
    chk("ldB_c4_stall", stall_b, 0);
    chk("ldB_cnt", cnt_b, 3);
`endif
    tick();
    do_reset();

    // Non-writer, r0 and unused-source cases never hit
    drive(1, 2, 1, 1, 8, 0, 0, 1);
    tick();
    drive(8, 0, 1, 1, 0, 1, 0, 1);
    chk("nowe_stall", stall_a, 0);
    chk("nowe_sel1", sel1_a, 0);
    tick();
    drive(0, 0, 1, 1, 9, 1, 0, 1);
    chk("r0_stall", stall_a, 0);
    chk("r0_sel1", sel1_a, 0);
    tick();
    drive(1, 9, 1, 0, 10, 1, 0, 1);
    chk("unused_stall", stall_a, 0);
    chk("unused_sel2", sel2_a, 0);
    tick();
    do_reset();

    // r7 written by three instructions in a row
    drive(1, 2, 1, 1, 7, 1, 0, 1);
    tick();
    drive(1, 2, 1, 1, 7, 1, 0, 1);
    tick();
    drive(1, 2, 1, 1, 7, 1, 0, 1);
    chk("r7_w3_stall", stall_a, 0);
    tick();
    drive(7, 7, 1, 1, 11, 1, 0, FWD);
    chk("r7_stall", stall_a, {31'd0, ~FWD});
    chk("r7_sel1", sel1_a, FWD ? 32'd1 : 32'd0);
    chk("r7_sel2", sel2_a, FWD ? 32'd1 : 32'd0);
    tick();
    drive(7, 0, 1, 0, 12, 1, 0, 0);
    chk("r7_mem_sel1", sel1_a, FWD ? 32'd2 : 32'd0);
    chk("r7_mem_stall", stall_a, {31'd0, ~FWD});
    tick();
    do_reset();

    // Reset while a load-use stall is in progress
    drive(1, 0, 1, 0, 5, 1, 1, 1);
    tick();
    drive(5, 1, 1, 1, 6, 1, 0, 0);
    chk("mid_c1_stall", stall_b, 1);
    tick();
    drive(5, 1, 1, 1, 6, 1, 0, 0);
    chk("mid_c2_stall", stall_b, 1);
    chk("mid_c2_cnt", cnt_b, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_stall", stall_b, 0);
    chk("mid_rst_cnt", cnt_b, 0);
    chk("mid_rst_sel1", sel1_b, 0);
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rel_stall", stall_b, 0);
    chk("mid_rel_sel1", sel1_b, 0);
    tick();
    chk("mid_rel2_stall", stall_b, 0);
    chk("mid_rel2_cnt", cnt_b, 0);
    drive(1, 0, 1, 0, 5, 1, 1, 1);
    tick();
    drive(5, 1, 1, 1, 6, 1, 0, 0);
    chk("mid_new_stall", stall_b, 1);
    tick();
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ds_hazard_ctrl.md
Name: ds_hazard_ctrl

Overview:
Scoreboard and interlock controller for the decode stage of the 5-stage in-order core (IF/ID/EX/MEM/WB).
- Tracks the destination register of every instruction in flight in EX, MEM and WB.
- Compares them against the decode-stage source registers.
- Drives the decode stall (`ds_ready_go` = `~ds_stall`) and per-operand forwarding selects used by the decode operand muxes.
- Keeps a stall-cycle performance counter.

Parameters:
- `REG_AW`, 5, register-address width.
- `CNT_W`, 32, stall-counter width.
- `LOAD_FWD_FROM_MEM`, 1.
  - 1: load data is forwardable from MEM.
  - 0: load data is forwardable only from WB.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous reset, active-low.
- `ds_valid`  in  1  decode stage holds a valid instruction.
- `ds_raddr1`  in  REG_AW  source 1 address (rj).
- `ds_raddr2`  in  REG_AW  source 2 address (rk, or rd for beq/bne/st.w).
- `ds_src1_used`  in  1  source 1 is actually read.
- `ds_src2_used`  in  1  source 2 is actually read.
- `ds_dest`  in  REG_AW  decode destination register.
- `ds_gr_we`  in  1  decode instruction writes the GPR file.
- `ds_is_load`  in  1  decode instruction is ld.w.
- `ds_go`  in  1  ID→EX transfer this cycle (`ds_to_es_valid & es_allow_in`).
- `es_go`  in  1  EX→MEM transfer this cycle.
- `ms_go`  in  1  MEM→WB transfer this cycle.
- `ws_go`  in  1  WB retires and writes the RF this cycle.
- `ds_stall`  out  1  decode must hold; `ds_ready_go` = `~ds_stall`.
- `fwd_sel1`  out  2  source-1 select: 00 RF, 01 EX result, 10 MEM result, 11 WB result.
- `fwd_sel2`  out  2  source-2 select, same encoding.
- `stall_cnt`  out  CNT_W  count of cycles with `ds_valid & ds_stall`.

Behaviour:
- Stage tags
  - One tag register each for EX, MEM, WB: {v, dest, ld}.
  - Asynchronous reset (`rst`=0): all v=0, dest=0, ld=0, `stall_cnt`=0.
  - Outputs during reset: `ds_stall`=0, `fwd_sel1`/`fwd_sel2`=00.
- Tag update at `posedge clk`
  - EX tag: if `ds_go`, load {`ds_gr_we` & (`ds_dest`!=0), `ds_dest`, `ds_is_load`}; else if `es_go`, clear v; else hold.
  - MEM tag: if `es_go`, load the EX tag; else if `ms_go`, clear v; else hold.
  - WB tag: if `ms_go`, load the MEM tag; else if `ws_go`, clear v; else hold.
  - Simultaneous load and leave in one stage: load wins (the pipeline advances).
- Hit detection (combinational)
  - `hitX_s` = `ds_valid` & `ds_srcS_used` & (`ds_raddrS`!=0) & X.v & (X.dest == `ds_raddrS`).
  - Register r0 never hits.
- Priority: youngest producer wins, EX > MEM > WB.
- Stall on any source whose winning hit is one of:
  - EX with ld=1 (load-use);
  - MEM with ld=1 when `LOAD_FWD_FROM_MEM`=0.
- Otherwise `fwd_selS` encodes the winning stage, or 00 if there is no hit.
- While `ds_stall`=1:
  - `fwd_sel` outputs still show the computed value, but consumers must ignore them;
  - `ds_go` must be 0 (the top level guarantees this via `ds_ready_go`).
- Stall latency: load-use stalls 1 cycle with `LOAD_FWD_FROM_MEM`=1, 2 cycles with 0.
- Counter: `stall_cnt` increments each cycle with `ds_valid & ds_stall`; wraps at 2^CNT_W.
- All outputs other than the tags and `stall_cnt` are purely combinational from current inputs and tags; zero-cycle latency.
- Reset asserted mid-operation clears all tags immediately; the first cycle after release shows no hazards.

Optional Feature:
- `DS_HAZARD_FWD_EN`
  - Defined: forwarding as described above.
  - Undefined:
    - `fwd_sel1`/`fwd_sel2` are tied to 00;
    - any hit in EX, MEM or WB stalls, regardless of ld;
    - non-load RAW stall is 3 cycles (until the producer passes `ws_go`, since the RF has no write-through);
    - `LOAD_FWD_FROM_MEM` is ignored.

Decomposition:
- Shared package/header (`DEFINE.vh`):
  - `FWD_RF`=2'b00, `FWD_ES`=2'b01, `FWD_MS`=2'b10, `FWD_WS`=2'b11;
  - `REG_AW`;
  - tag-width define `HZ_TAG_WD` = 1+REG_AW+1.
- Sub-module `hz_src_check`, instantiated twice (one per source):
  - inputs: address, used flag, three tags;
  - outputs: stall request and select.
- The top-level block ORs the two stall requests.

Test Plan:
- add.w r3,r1,r2 then add.w r4,r3,r0 back-to-back.
  - Second instruction in ID: `fwd_sel1`=01, `ds_stall`=0.
  - One cycle later, if it stalls: 10.
- ld.w r5 then add.w r6,r5,r5, `LOAD_FWD_FROM_MEM`=1.
  - `ds_stall`=1 for exactly 1 cycle; then `fwd_sel1`=`fwd_sel2`=10.
  - `stall_cnt` goes 0→1.
- Same pair with `LOAD_FWD_FROM_MEM`=0.
  - 2 stall cycles, then select 11; `stall_cnt`=2.
- Producer writes r0, or consumer has `ds_src2_used`=0 on a matching address.
  - `ds_stall`=0, selects 00.
- r7 written in EX, MEM and WB simultaneously (three writers in a row), consumer reads r7.
  - `fwd_sel1`=01 (youngest wins).
- Assert `rst`=0 while a load sits in EX with a dependent instruction stalled in ID.
  - Immediately `ds_stall`=0 and `stall_cnt`=0.
  - After release, no hit until a new `ds_go`.
- `DS_HAZARD_FWD_EN` undefined: add.w r3 then dependent add.w.
  - Stall 3 cycles, selects stay 00.
